// File: rtl/b_i_l_type.sv
// RV32 I-type ALU, load extractor and branch next-PC unit. All outputs registered (latency 1), en=0 holds them.
// Define BIL_ILLEGAL_EN to add the registered 'illegal' flag for undefined funct3 encodings.
module b_i_l_type #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [XLEN-1:0] idata,
    input  logic [XLEN-1:0] iaddr,
    input  logic [XLEN-1:0] rv1,
    input  logic [XLEN-1:0] rv2,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] daddr,
    input  logic [XLEN-1:0] drdata,
    output logic [XLEN-1:0] regdata_I,
    output logic [XLEN-1:0] regdata_L,
    output logic [XLEN-1:0] iaddr_val
`ifdef BIL_ILLEGAL_EN
    ,
    output logic            illegal
`endif
);

    logic [2:0]      f3;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] load_res;
    logic [XLEN-1:0] next_pc;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic            taken;
    logic            unused_bits;

    assign f3    = idata[14:12];
    assign shamt = idata[24:20];

    // Only the lane-select bits of daddr matter; the word was already fetched.
    assign unused_bits = ^{idata, daddr};

    always_comb begin
        alu_res = '0;
        unique case (f3)
            3'b000: alu_res = rv1 + imm;
            3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(rv1) < $signed(imm))};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, (rv1 < imm)};
            3'b100: alu_res = rv1 ^ imm;
            3'b110: alu_res = rv1 | imm;
            3'b111: alu_res = rv1 & imm;
            3'b001: alu_res = rv1 << shamt;
            3'b101: alu_res = idata[30] ? XLEN'($signed(rv1) >>> shamt) : (rv1 >> shamt);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        ld_byte = drdata[{daddr[1:0], 3'b000} +: 8];
        ld_half = daddr[1] ? drdata[31:16] : drdata[15:0];
        load_res = '0;
        unique case (f3)
            3'b000: load_res = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001: load_res = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b010: load_res = drdata;
            3'b100: load_res = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101: load_res = {{(XLEN-16){1'b0}}, ld_half};
            default: load_res = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        unique case (f3)
            3'b000: taken = (rv1 == rv2);
            3'b001: taken = (rv1 != rv2);
            3'b100: taken = ($signed(rv1) < $signed(rv2));
            3'b101: taken = ($signed(rv1) >= $signed(rv2));
            3'b110: taken = (rv1 < rv2);
            3'b111: taken = (rv1 >= rv2);
            default: taken = 1'b0;
        endcase
        next_pc = iaddr + (taken ? imm : XLEN'(4));
    end

`ifdef BIL_ILLEGAL_EN
    logic       illegal_nxt;
    logic [6:0] opcode;
    logic [6:0] funct7;

    assign opcode = idata[6:0];
    assign funct7 = idata[31:25];

    always_comb begin
        illegal_nxt = 1'b0;
        unique case (opcode)
            7'b0010011: illegal_nxt = ((f3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000))
                                   || ((f3 == 3'b001) && (funct7 != 7'b0000000));
            7'b0000011: illegal_nxt = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            7'b1100011: illegal_nxt = (f3 == 3'b010) || (f3 == 3'b011);
            default:    illegal_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal <= 1'b0;
        end else if (en) begin
            illegal <= illegal_nxt;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regdata_I <= '0;
            regdata_L <= '0;
            iaddr_val <= '0;
        end else if (en) begin
            regdata_I <= alu_res;
            regdata_L <= load_res;
            iaddr_val <= next_pc;
        end
    end

endmodule

// File: tb/tb_b_i_l_type.sv
// Randomized and directed bench for b_i_l_type against an arithmetic reference model.
module tb_b_i_l_type;

    localparam longint TWO32 = 64'h1_0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] idata, iaddr, rv1, rv2, imm, daddr, drdata;
    logic [31:0] regdata_I, regdata_L, iaddr_val;
`ifdef BIL_ILLEGAL_EN
    logic        illegal;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_i = '0, exp_l = '0, exp_p = '0;
    logic        exp_ill = 1'b0;

    b_i_l_type #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .en(en), .idata(idata), .iaddr(iaddr),
        .rv1(rv1), .rv2(rv2), .imm(imm), .daddr(daddr), .drdata(drdata),
        .regdata_I(regdata_I), .regdata_L(regdata_L), .iaddr_val(iaddr_val)
`ifdef BIL_ILLEGAL_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    function automatic longint u(input logic [31:0] x);
        return longint'({32'b0, x});
    endfunction

    function automatic longint sv(input logic [31:0] x);
        return x[31] ? u(x) - TWO32 : u(x);
    endfunction

    function automatic logic [31:0] m_alu(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        longint t;
        int sh;
        sh = int'(ins[24:20]);
        t = 0;
        case (ins[14:12])
            3'd0: t = sv(a) + sv(b);
            3'd1: t = u(a) * (64'd1 << sh);
            3'd2: t = (sv(a) < sv(b)) ? 1 : 0;
            3'd3: t = (u(a) < u(b)) ? 1 : 0;
            3'd4: t = u(a ^ b);
            3'd5: t = ins[30] ? (sv(a) >>> sh) : (u(a) / (64'd1 << sh));
            3'd6: t = u(a | b);
            default: t = u(a & b);
        endcase
        return t[31:0];
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] w, input logic [31:0] ad);
        int     bytes [4];
        longint b, h, t;
        for (int i = 0; i < 4; i++) bytes[i] = int'(w[8*i +: 8]);
        b = bytes[ad[1:0]];
        h = bytes[2*ad[1]] + 256 * bytes[2*ad[1] + 1];
        case (f)
            3'd0: t = (b >= 128) ? b - 256 : b;
            3'd1: t = (h >= 32768) ? h - 65536 : h;
            3'd2: t = u(w);
            3'd4: t = b;
            3'd5: t = h;
            default: t = 0;
        endcase
        return t[31:0];
    endfunction

    function automatic logic [31:0] m_pc(input logic [2:0] f, input logic [31:0] pc,
                                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        bit     tk;
        longint t;
        case (f)
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = sv(a) < sv(b);
            3'd5: tk = sv(a) >= sv(b);
            3'd6: tk = u(a) < u(b);
            3'd7: tk = u(a) >= u(b);
            default: tk = 1'b0;
        endcase
        t = u(pc) + (tk ? u(im) : 64'd4);
        return t[31:0];
    endfunction

    function automatic logic m_ill(input logic [31:0] ins);
        logic [2:0] f;
        logic [6:0] f7;
        f  = ins[14:12];
        f7 = ins[31:25];
        if (ins[6:0] == 7'h13) return (f == 3'd5 && f7 != 7'h00 && f7 != 7'h20) || (f == 3'd1 && f7 != 7'h00);
        if (ins[6:0] == 7'h03) return f inside {3'd3, 3'd6, 3'd7};
        if (ins[6:0] == 7'h63) return f inside {3'd2, 3'd3};
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".I"}, regdata_I, exp_i);
        chk({tag, ".L"}, regdata_L, exp_l);
        chk({tag, ".PC"}, iaddr_val, exp_p);
`ifdef BIL_ILLEGAL_EN
        chk({tag, ".ILL"}, {31'b0, illegal}, {31'b0, exp_ill});
`endif
    endtask

    // One clock edge; the model captures exactly what the DUT sampled.
    task automatic step(input string tag);
        @(posedge clk);
        #1;
        if (reset) begin
            exp_i = '0; exp_l = '0; exp_p = '0; exp_ill = 1'b0;
        end else if (en) begin
            exp_i   = m_alu(idata, rv1, imm);
            exp_l   = m_load(idata[14:12], drdata, daddr);
            exp_p   = m_pc(idata[14:12], iaddr, rv1, rv2, imm);
            exp_ill = m_ill(idata);
        end
        chk_all(tag);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic randomize_inputs();
        logic [6:0] ops [4];
        ops[0] = 7'h13; ops[1] = 7'h03; ops[2] = 7'h63; ops[3] = 7'h33;
        idata = $urandom;
        idata[6:0] = ops[$urandom_range(0, 3)];
        if ($urandom_range(0, 1) == 1) idata[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        rv1    = pick();
        rv2    = ($urandom_range(0, 3) == 0) ? rv1 : pick();
        imm    = pick();
        iaddr  = $urandom;
        daddr  = $urandom;
        drdata = $urandom;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1;
        idata = '0; iaddr = '0; rv1 = '0; rv2 = '0; imm = '0; daddr = '0; drdata = '0;
        #2;
        chk_all("reset_state");
        step("reset_held");
        reset = 1'b0;

        idata = 32'h0000_0013; rv1 = 32'd5; imm = 32'hFFFF_FFFD;
        step("addi_model");
        chk("addi_neg", regdata_I, 32'd2);

        idata = 32'h4040_5013; rv1 = 32'h8000_0000;
        step("srai_model");
        chk("srai", regdata_I, 32'hF800_0000);
        idata = 32'h0040_5013;
        step("srli_model");
        chk("srli", regdata_I, 32'h0800_0000);

        idata = 32'h0000_0013; rv1 = 32'h1234_5678;
        idata[24:20] = 5'd0; idata[14:12] = 3'b001;
        step("slli0_model");
        chk("slli0", regdata_I, 32'h1234_5678);

        drdata = 32'h80FF_7F01; daddr = 32'h0000_1002;
        idata = 32'h0000_0003;
        step("lb_model");
        chk("lb", regdata_L, 32'hFFFF_FFFF);
        idata = 32'h0000_4003;
        step("lbu_model");
        chk("lbu", regdata_L, 32'h0000_00FF);
        idata = 32'h0000_5003;
        step("lhu_model");
        chk("lhu", regdata_L, 32'h0000_80FF);
        daddr = 32'h0000_1003;
        step("lhu_mis_model");
        chk("lhu_misaligned", regdata_L, 32'h0000_80FF);

        iaddr = 32'h100; imm = 32'hFFFF_FFF0; rv1 = 32'hFFFF_FFFF; rv2 = 32'd1;
        idata = 32'h0000_4063;
        step("blt_model");
        chk("blt", iaddr_val, 32'h0000_00F0);
        idata = 32'h0000_6063;
        step("bltu_model");
        chk("bltu", iaddr_val, 32'h0000_0104);

        // Hold: outputs must stay put while inputs churn.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            step("hold");
            chk("hold_pc", iaddr_val, 32'h0000_0104);
        end

        // Reset landing mid-cycle clears immediately and drops the pending capture.
        en = 1'b1;
        randomize_inputs();
        #2 reset = 1'b1;
        #1;
        exp_i = '0; exp_l = '0; exp_p = '0; exp_ill = 1'b0;
        chk_all("reset_async");
        step("reset_over_edge");
        #2 reset = 1'b0;
        randomize_inputs();
        step("after_reset");

`ifdef BIL_ILLEGAL_EN
        idata = 32'h0000_2063; iaddr = 32'h200;
        step("bill_model");
        chk("b_f3_010_ill", {31'b0, illegal}, 32'd1);
        chk("b_f3_010_pc", iaddr_val, 32'h204);
        idata = 32'h0000_0033; idata[14:12] = 3'($urandom_range(0, 7));
        step("rtype_model");
        chk("rtype_ill", {31'b0, illegal}, 32'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            en = ($urandom_range(0, 4) != 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/b_i_l_type.md
B_I_L_TYPE -- requirements
Module: b_i_l_type

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, meaning the datapath width; only the value 32 is supported.
REQ-002 The block SHALL use clock clk and reset reset; reset is asynchronous and active-high.
REQ-003 The ports SHALL be, one per line:
- clk  input  1  rising-edge clock
- reset  input  1  async active-high reset
- en  input  1  capture enable; low holds all outputs
- idata  input  32  instruction word
- iaddr  input  32  PC of idata
- rv1  input  32  rs1 value
- rv2  input  32  rs2 value
- imm  input  32  pre-decoded sign-extended immediate (I or B format)
- daddr  input  32  load byte address
- drdata  input  32  aligned data-memory word at daddr[31:2]
- regdata_I  output  32  I-type ALU result
- regdata_L  output  32  load result
- iaddr_val  output  32  next PC for branch
- illegal  output  1  undefined funct3 for decoded opcode (only with BIL_ILLEGAL_EN)

Function
REQ-004 All outputs SHALL be registered: values computed from inputs sampled at a rising clk edge with en=1 SHALL appear after that edge (latency 1); with en=0 outputs SHALL hold.
REQ-005 All three results SHALL be computed every enabled cycle from idata[14:12] (f3) regardless of opcode.
REQ-006 regdata_I by f3: 000 rv1+imm (mod 2^32); 010 signed rv1<imm ? 1:0; 011 unsigned rv1<imm ? 1:0; 100 rv1^imm; 110 rv1|imm; 111 rv1&imm; 001 rv1<<idata[24:20]; 101 idata[30]=0 logical right shift, idata[30]=1 arithmetic right shift, by idata[24:20].
REQ-007 Shift amount SHALL use only idata[24:20]; shift by 0 SHALL return rv1 unchanged.
REQ-008 Loads SHALL be little-endian; byte lane = daddr[1:0], halfword lane = daddr[1].
REQ-009 regdata_L by f3: 000 LB sign-extend; 001 LH sign-extend; 010 LW drdata; 100 LBU zero-extend; 101 LHU zero-extend; 011/110/111 SHALL yield 0.
REQ-010 Misaligned halfword (daddr[0]=1) SHALL ignore daddr[0]; LW SHALL ignore daddr[1:0]; no fault raised.
REQ-011 Branch condition by f3: 000 rv1==rv2; 001 rv1!=rv2; 100 signed rv1<rv2; 101 signed rv1>=rv2; 110 unsigned rv1<rv2; 111 unsigned rv1>=rv2; 010/011 never taken.
REQ-012 iaddr_val SHALL be iaddr+imm when taken, else iaddr+4, both mod 2^32 (wrap-around allowed, no flag).
REQ-013 Signed/unsigned comparisons SHALL differ correctly at the 0x80000000 boundary.

Reset
REQ-014 While reset=1, regdata_I, regdata_L, iaddr_val and illegal SHALL be 0, immediately and independent of clk and en.
REQ-015 Reset asserted mid-stream SHALL discard the in-flight capture; the first enabled edge after release SHALL load fresh results.

Configuration
REQ-016 Macro BIL_ILLEGAL_EN defined: port illegal SHALL exist, registered like the results, 1 when opcode idata[6:0] is 0010011 (I) with f3=101 and idata[31:25] not 0000000/0100000, or f3=001 and idata[31:25]!=0, or 0000011 (L) with f3 in {011,110,111}, or 1100011 (B) with f3 in {010,011}; else 0.
REQ-017 Macro undefined: port illegal SHALL be absent and no related logic present; all other behaviour identical.

Verification
REQ-018 f3=000, rv1=5, imm=0xFFFFFFFD, en=1 -> regdata_I=2 after one edge.
REQ-019 f3=101, idata[30]=1, idata[24:20]=4, rv1=0x80000000 -> regdata_I=0xF8000000; idata[30]=0 -> 0x08000000.
REQ-020 drdata=0x80FF7F01, daddr[1:0]=2, f3=000 -> regdata_L=0xFFFFFFFF; f3=100 -> 0x000000FF; f3=101, daddr[1]=1 -> 0x000080FF.
REQ-021 iaddr=0x100, imm=0xFFFFFFF0, rv1=0xFFFFFFFF, rv2=1: f3=100 -> iaddr_val=0xF0; f3=110 -> 0x104.
REQ-022 Load results, drop en for 3 cycles with changing inputs -> outputs unchanged; assert reset mid-cycle -> all outputs 0 before next edge.
REQ-023 With BIL_ILLEGAL_EN: idata opcode 1100011, f3=010 -> illegal=1, iaddr_val=iaddr+4; opcode 0110011 any f3 -> illegal=0.
